idct_block_scheduler: RTL
=========================

IDCT_BLOCK_SCHEDULER -- requirements
Module: idct_block_scheduler

Interface
REQ-001 Parameters SHALL be: PRE_IDCT_BASE, 76800, SRAM word address of the first Y pre-IDCT sample.
REQ-002 Parameter U_POST_BASE, 38400, SHALL be the SRAM word address of U output.
REQ-003 Parameter V_POST_BASE, 57600, SHALL be the SRAM word address of V output.
REQ-004 Ports SHALL be, as name, direction, width, meaning:
- Clock, in, 1, rising-edge clock.
- Resetn, in, 1, asynchronous active-low reset.
- Start, in, 1, one-cycle request to decode a frame.
- Busy, out, 1, high from the cycle after an accepted Start until Done.
- Done, out, 1, one-cycle pulse when the frame is finished.
- FS_start / FS_done, out / in, 1 each, fetch-S' engine handshake.
- FS_pre_addr, out, 18, top-left pre-IDCT word of the block being fetched.
- FS_y_seg, out, 1, fetched block is Y: row stride 320, else 160.
- CT_start / CT_done, out / in, 1 each, compute-T engine handshake.
- CS_start / CS_done, out / in, 1 each, compute-S engine handshake.
- WS_start / WS_done, out / in, 1 each, write-S engine handshake.
- WS_post_addr, out, 18, top-left output word of the block being written.
- WS_y_seg, out, 1, written block is Y: row stride 160, else 80.
- SP_bank, out, 1, S' RAM bank that FS writes; CT reads the other bank.
- SRAM_owner, out, 2, SRAM mux select: 0 none, 1 FS, 2 WS.
- Cycle_count, out, 32, statistics (see Configuration).

Function
REQ-005 Frame SHALL be 2400 blocks in order: Y 40x30, then U 20x30, then V 20x30; each segment row-major.
REQ-006 FS_pre_addr SHALL be PRE_IDCT_BASE + seg_off + brow*8*stride + bcol*8.
- seg_off: Y 0, U 76800, V 115200.
- stride: Y 320, U/V 160.
REQ-007 WS_post_addr SHALL be seg_base + brow*8*pstride + bcol*4.
- seg_base: Y 0, U U_POST_BASE, V V_POST_BASE.
- pstride: Y 160, U/V 80.
REQ-008 FSM states SHALL be IDLE, LI_FS, MS_A, MS_B, LO_WS, FIN.
REQ-009 IDLE: Start SHALL move the FSM to LI_FS; Start in any other state SHALL be ignored.
REQ-010 LI_FS SHALL fetch block 0, then go to MS_A with n=0.
REQ-011 MS_A SHALL run CT(n), plus FS(n+1) if n<2399, then go to MS_B.
REQ-012 MS_B SHALL run CS(n), plus WS(n-1) if n>0.
- If n<2399: increment n and go to MS_A.
- Else: go to LO_WS.
REQ-013 LO_WS SHALL write block 2399, then go to FIN.
REQ-014 FIN SHALL pulse Done for one cycle, then return to IDLE.
REQ-015 On entry to a phase, start pulses SHALL be one cycle, asserted together, one cycle after the state is entered.
REQ-016 Per-engine sticky done flags SHALL be cleared at phase entry and set by the done input.
REQ-017 The FSM SHALL leave a phase in the first cycle after all started engines' flags are set; minimum phase length is 3 cycles.
REQ-018 A done input from an engine not started in the current phase, or coincident with its own start pulse, SHALL be ignored.
REQ-019 Done inputs from the two engines arriving in different cycles SHALL be accepted in any order.
REQ-020 SP_bank SHALL toggle on every MS_B to MS_A transition.
REQ-021 SRAM_owner SHALL be 1 in LI_FS and in MS_A with FS active, 2 in MS_B with WS active and in LO_WS, otherwise 0.
REQ-022 FS_pre_addr, FS_y_seg, WS_post_addr and WS_y_seg SHALL be registered and stable from the start pulse until the phase ends.
REQ-023 Address arithmetic SHALL be unsigned 18-bit; block counters SHALL wrap from column end to next row and from the last row to the next segment.

Reset
REQ-024 Resetn low SHALL force IDLE and n=0.
- Outputs: all start pulses, Busy, Done and SRAM_owner 0; SP_bank 0; addresses 0; Cycle_count 0.
REQ-025 Reset mid-frame SHALL abandon the frame immediately; no Done is issued.

Configuration
REQ-026 With IDCT_SCHED_STATS_EN defined, Cycle_count SHALL count cycles while Busy, clear on accepted Start, and hold after Done.
REQ-027 Without IDCT_SCHED_STATS_EN, Cycle_count SHALL be constant 0 and no counter logic SHALL be generated.

Structure
REQ-028 A shared package SHALL hold the state enum, SRAM_owner codes, base addresses, segment offsets, strides and block counts.
REQ-029 The block-position counter SHALL be one sub-module, idct_block_counter, instantiated twice (fetch position, write position).

Verification
REQ-030 Start, all engines done 5 cycles after start -> FS_pre_addr 76800 then 76808; Done after 2400 MS_A/MS_B pairs.
REQ-031 Block 40 fetch -> FS_pre_addr 79360; block 1200 -> 153600 with FS_y_seg 0; WS for block 1200 -> WS_post_addr 38400.
REQ-032 MS_A with CT_done at cycle 3 and FS_done at cycle 9 -> phase exits at cycle 10; with reverse order -> same exit.
REQ-033 Spurious WS_done during MS_A, and Start while Busy -> both ignored; no state change.
REQ-034 Resetn low during MS_B of block 7 -> all outputs at reset values next cycle; a new Start begins again at block 0.
REQ-035 With IDCT_SCHED_STATS_EN and all engines done 2 cycles after start -> Cycle_count equals Busy-high cycles; without the macro -> Cycle_count stays 0.

Source files
------------

// File: rtl/idct_block_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  idct_block_scheduler_pkg
//  Shared states, segment geometry, base addresses and address helpers.
//  Revision: 1.0
// ============================================================================
package idct_block_scheduler_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LI_FS = 3'd1,
    MS_A  = 3'd2,
    MS_B  = 3'd3,
    LO_WS = 3'd4,
    FIN   = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    SEG_Y = 2'd0,
    SEG_U = 2'd1,
    SEG_V = 2'd2
  } seg_e;

  localparam logic [1:0]  C_OWN_NONE        = 2'd0;
  localparam logic [1:0]  C_OWN_FS          = 2'd1;
  localparam logic [1:0]  C_OWN_WS          = 2'd2;

  localparam logic [17:0] C_PRE_IDCT_BASE   = 18'd76800;
  localparam logic [17:0] C_U_POST_BASE     = 18'd38400;
  localparam logic [17:0] C_V_POST_BASE     = 18'd57600;

  localparam logic [17:0] C_SEG_OFF_Y       = 18'd0;
  localparam logic [17:0] C_SEG_OFF_U       = 18'd76800;
  localparam logic [17:0] C_SEG_OFF_V       = 18'd115200;

  localparam logic [17:0] C_PRE_STRIDE_Y    = 18'd320;
  localparam logic [17:0] C_PRE_STRIDE_UV   = 18'd160;
  localparam logic [17:0] C_POST_STRIDE_Y   = 18'd160;
  localparam logic [17:0] C_POST_STRIDE_UV  = 18'd80;

  localparam logic [5:0]  C_BCOLS_Y         = 6'd40;
  localparam logic [5:0]  C_BCOLS_UV        = 6'd20;
  localparam logic [4:0]  C_BROWS           = 5'd30;
  localparam logic [11:0] C_LAST_BLOCK      = 12'd2399;

  function automatic seg_e next_seg(input seg_e s);
    case (s)
      SEG_Y:   return SEG_U;
      SEG_U:   return SEG_V;
      default: return SEG_Y;
    endcase
  endfunction

  function automatic logic [5:0] seg_bcols(input seg_e s);
    return (s == SEG_Y) ? C_BCOLS_Y : C_BCOLS_UV;
  endfunction

  // Offset from PRE_IDCT_BASE of the block's top-left sample (8 rows per block row).
  function automatic logic [17:0] pre_offset(input seg_e s, input logic [4:0] brow,
                                             input logic [5:0] bcol);
    logic [17:0] off;
    logic [17:0] stride;
    case (s)
      SEG_Y:   off = C_SEG_OFF_Y;
      SEG_U:   off = C_SEG_OFF_U;
      default: off = C_SEG_OFF_V;
    endcase
    stride = (s == SEG_Y) ? C_PRE_STRIDE_Y : C_PRE_STRIDE_UV;
    return off + ((18'(brow) * stride) << 3) + (18'(bcol) << 3);
  endfunction

  function automatic logic [17:0] post_offset(input seg_e s, input logic [4:0] brow,
                                              input logic [5:0] bcol);
    logic [17:0] stride;
    stride = (s == SEG_Y) ? C_POST_STRIDE_Y : C_POST_STRIDE_UV;
    return ((18'(brow) * stride) << 3) + (18'(bcol) << 2);
  endfunction

endpackage
`default_nettype wire

// File: rtl/idct_block_counter.sv
`default_nettype none
// ============================================================================
//  idct_block_counter
//  Row-major block position walker over the Y, U and V segments of a frame.
//  Revision: 1.0
// ============================================================================
module idct_block_counter
  import idct_block_scheduler_pkg::*;
(
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       i_clear,
  input  logic       i_advance,
  output seg_e       o_seg,
  output logic [4:0] o_brow,
  output logic [5:0] o_bcol
);

  logic w_last_col;
  logic w_last_row;

  assign w_last_col = (o_bcol == seg_bcols(o_seg) - 6'd1);
  assign w_last_row = (o_brow == C_BROWS - 5'd1);

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      o_seg  <= SEG_Y;
      o_brow <= '0;
      o_bcol <= '0;
    end else if (i_clear) begin
      o_seg  <= SEG_Y;
      o_brow <= '0;
      o_bcol <= '0;
    end else if (i_advance) begin
      if (!w_last_col) begin
        o_bcol <= o_bcol + 6'd1;
      end else begin
        o_bcol <= '0;
        if (!w_last_row) begin
          o_brow <= o_brow + 5'd1;
        end else begin
          o_brow <= '0;
          o_seg  <= next_seg(o_seg);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/idct_block_scheduler.sv
`default_nettype none
// ============================================================================
//  idct_block_scheduler
//  Pipelines fetch/compute/write engines over the 2400 blocks of a frame.
//  Optional Cycle_count statistics: define IDCT_SCHED_STATS_EN.
//  Revision: 1.0
// ============================================================================
module idct_block_scheduler
  import idct_block_scheduler_pkg::*;
#(
  parameter logic [17:0] PRE_IDCT_BASE = C_PRE_IDCT_BASE,
  parameter logic [17:0] U_POST_BASE   = C_U_POST_BASE,
  parameter logic [17:0] V_POST_BASE   = C_V_POST_BASE
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        Start,
  output logic        Busy,
  output logic        Done,
  output logic        FS_start,
  input  logic        FS_done,
  output logic [17:0] FS_pre_addr,
  output logic        FS_y_seg,
  output logic        CT_start,
  input  logic        CT_done,
  output logic        CS_start,
  input  logic        CS_done,
  output logic        WS_start,
  input  logic        WS_done,
  output logic [17:0] WS_post_addr,
  output logic        WS_y_seg,
  output logic        SP_bank,
  output logic [1:0]  SRAM_owner,
  output logic [31:0] Cycle_count
);

  state_e      r_state;
  logic [11:0] r_n;
  logic        r_entry;
  logic        r_fs_act, r_ct_act, r_cs_act, r_ws_act;
  logic        r_fs_dn, r_ct_dn, r_cs_dn, r_ws_dn;

  logic        w_start_acc, w_in_phase, w_phase_done;
  logic        w_fs_acc, w_ct_acc, w_cs_acc, w_ws_acc;
  seg_e        w_f_seg, w_w_seg;
  logic [4:0]  w_f_brow, w_w_brow;
  logic [5:0]  w_f_bcol, w_w_bcol;
  logic [17:0] w_post_base;

  assign w_start_acc = (r_state == IDLE) && Start;

  // A done counts only after its own start pulse has gone by in this phase.
  assign w_fs_acc = r_fs_act && !r_entry && !FS_start && FS_done;
  assign w_ct_acc = r_ct_act && !r_entry && !CT_start && CT_done;
  assign w_cs_acc = r_cs_act && !r_entry && !CS_start && CS_done;
  assign w_ws_acc = r_ws_act && !r_entry && !WS_start && WS_done;

  assign w_in_phase = (r_state == LI_FS) || (r_state == MS_A) ||
                      (r_state == MS_B)  || (r_state == LO_WS);

  assign w_phase_done = w_in_phase && !r_entry &&
                        (!r_fs_act || r_fs_dn || w_fs_acc) &&
                        (!r_ct_act || r_ct_dn || w_ct_acc) &&
                        (!r_cs_act || r_cs_dn || w_cs_acc) &&
                        (!r_ws_act || r_ws_dn || w_ws_acc);

  idct_block_counter u_fetch_pos (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .i_clear   (w_start_acc),
    .i_advance (r_entry && r_fs_act),
    .o_seg     (w_f_seg),
    .o_brow    (w_f_brow),
    .o_bcol    (w_f_bcol)
  );

  idct_block_counter u_write_pos (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .i_clear   (w_start_acc),
    .i_advance (r_entry && r_ws_act),
    .o_seg     (w_w_seg),
    .o_brow    (w_w_brow),
    .o_bcol    (w_w_bcol)
  );

  always_comb begin
    w_post_base = '0;
    case (w_w_seg)
      SEG_U:   w_post_base = U_POST_BASE;
      SEG_V:   w_post_base = V_POST_BASE;
      default: w_post_base = '0;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state      <= IDLE;
      r_n          <= '0;
      r_entry      <= 1'b0;
      {r_fs_act, r_ct_act, r_cs_act, r_ws_act} <= '0;
      {r_fs_dn, r_ct_dn, r_cs_dn, r_ws_dn}     <= '0;
      Busy         <= 1'b0;
      Done         <= 1'b0;
      FS_start     <= 1'b0;
      CT_start     <= 1'b0;
      CS_start     <= 1'b0;
      WS_start     <= 1'b0;
      FS_pre_addr  <= '0;
      FS_y_seg     <= 1'b0;
      WS_post_addr <= '0;
      WS_y_seg     <= 1'b0;
      SP_bank      <= 1'b0;
      SRAM_owner   <= C_OWN_NONE;
    end else begin
      FS_start <= 1'b0;
      CT_start <= 1'b0;
      CS_start <= 1'b0;
      WS_start <= 1'b0;
      Done     <= 1'b0;
      r_fs_dn  <= r_fs_dn | w_fs_acc;
      r_ct_dn  <= r_ct_dn | w_ct_acc;
      r_cs_dn  <= r_cs_dn | w_cs_acc;
      r_ws_dn  <= r_ws_dn | w_ws_acc;

      // Entry cycle: latch this phase's addresses and launch its engines together.
      if (r_entry) begin
        r_entry  <= 1'b0;
        FS_start <= r_fs_act;
        CT_start <= r_ct_act;
        CS_start <= r_cs_act;
        WS_start <= r_ws_act;
        if (r_fs_act) begin
          FS_pre_addr <= PRE_IDCT_BASE + pre_offset(w_f_seg, w_f_brow, w_f_bcol);
          FS_y_seg    <= (w_f_seg == SEG_Y);
        end
        if (r_ws_act) begin
          WS_post_addr <= w_post_base + post_offset(w_w_seg, w_w_brow, w_w_bcol);
          WS_y_seg     <= (w_w_seg == SEG_Y);
        end
      end

      if (w_start_acc || w_phase_done) begin
        r_entry <= 1'b1;
        {r_fs_dn, r_ct_dn, r_cs_dn, r_ws_dn} <= '0;
      end

      case (r_state)
        IDLE: begin
          if (Start) begin
            r_state    <= LI_FS;
            Busy       <= 1'b1;
            r_n        <= '0;
            {r_fs_act, r_ct_act, r_cs_act, r_ws_act} <= 4'b1000;
            SRAM_owner <= C_OWN_FS;
          end
        end
        LI_FS: begin
          if (w_phase_done) begin
            r_state    <= MS_A;
            {r_fs_act, r_ct_act, r_cs_act, r_ws_act} <= 4'b1100;
            SRAM_owner <= C_OWN_FS;
          end
        end
        MS_A: begin
          if (w_phase_done) begin
            r_state    <= MS_B;
            {r_fs_act, r_ct_act, r_cs_act, r_ws_act} <= {3'b001, (r_n != 12'd0)};
            SRAM_owner <= (r_n != 12'd0) ? C_OWN_WS : C_OWN_NONE;
          end
        end
        MS_B: begin
          if (w_phase_done) begin
            if (r_n != C_LAST_BLOCK) begin
              r_state    <= MS_A;
              r_n        <= r_n + 12'd1;
              SP_bank    <= ~SP_bank;
              {r_fs_act, r_ct_act, r_cs_act, r_ws_act} <=
                {(r_n < C_LAST_BLOCK - 12'd1), 3'b100};
              SRAM_owner <= (r_n < C_LAST_BLOCK - 12'd1) ? C_OWN_FS : C_OWN_NONE;
            end else begin
              r_state    <= LO_WS;
              {r_fs_act, r_ct_act, r_cs_act, r_ws_act} <= 4'b0001;
              SRAM_owner <= C_OWN_WS;
            end
          end
        end
        LO_WS: begin
          if (w_phase_done) begin
            r_state    <= FIN;
            r_entry    <= 1'b0;
            Busy       <= 1'b0;
            Done       <= 1'b1;
            {r_fs_act, r_ct_act, r_cs_act, r_ws_act} <= '0;
            SRAM_owner <= C_OWN_NONE;
          end
        end
        FIN: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

`ifdef IDCT_SCHED_STATS_EN
  logic [31:0] r_cycle_count;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_cycle_count <= '0;
    end else if (w_start_acc) begin
      r_cycle_count <= '0;
    end else if (Busy) begin
      r_cycle_count <= r_cycle_count + 32'd1;
    end
  end

  assign Cycle_count = r_cycle_count;
`else
  assign Cycle_count = 32'd0;
`endif

endmodule
`default_nettype wire
